// File: rtl/icache_dataram_sched_pkg.sv
// Shared icache types and sizing for the data-array scheduler and its MSHR-side helpers.
package toy_pack;

  localparam int MSHR_ENTRY_NUM         = 8;
  localparam int WAY_NUM                = 2;
  localparam int ICACHE_INDEX_WIDTH     = 7;
  localparam int ICACHE_REQ_TXNID_WIDTH = 8;
  localparam int MAX_WR_BURST           = 4;

  localparam int ICACHE_WAY_WIDTH       = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
  localparam int MSHR_ENTRY_INDEX_WIDTH = $clog2(MSHR_ENTRY_NUM);
  localparam int WR_STREAK_WIDTH        = $clog2(MAX_WR_BURST + 1);

  typedef struct packed {
    logic [ICACHE_WAY_WIDTH-1:0]       way;
    logic [ICACHE_INDEX_WIDTH-1:0]     index;
    logic [ICACHE_REQ_TXNID_WIDTH-1:0] txnid;
  } dataram_sched_req_t;

  // Round-robin pointer advance with explicit wrap, so non-power-of-two entry counts work.
  function automatic logic [MSHR_ENTRY_INDEX_WIDTH-1:0] next_rr_ptr(
    input logic [MSHR_ENTRY_INDEX_WIDTH-1:0] cur
  );
    if (cur == MSHR_ENTRY_INDEX_WIDTH'(MSHR_ENTRY_NUM - 1)) return '0;
    return cur + MSHR_ENTRY_INDEX_WIDTH'(1);
  endfunction

endpackage

// File: rtl/icache_dataram_sched_rr_arbiter.sv
// Round-robin arbiter: scans the request vector starting at ptr, returns one-hot and encoded winner.
module icache_rr_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  always_comb begin
    int j;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!gnt_vld && req[j]) begin
        gnt_vld = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/icache_dataram_sched.sv
// Single-port icache data-array scheduler: linefill writes vs. round-robin MSHR read replays,
// with a write-burst starvation guard and a one-cycle read-response tag stage.
module icache_dataram_sched
  import toy_pack::*;
(
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [MSHR_ENTRY_NUM-1:0]                          v_rd_req_vld,
  input  logic [MSHR_ENTRY_NUM*ICACHE_WAY_WIDTH-1:0]         v_rd_req_way,
  input  logic [MSHR_ENTRY_NUM*ICACHE_INDEX_WIDTH-1:0]       v_rd_req_index,
  input  logic [MSHR_ENTRY_NUM*ICACHE_REQ_TXNID_WIDTH-1:0]   v_rd_req_txnid,
  output logic [MSHR_ENTRY_NUM-1:0]                          v_rd_req_rdy,
  input  logic                                               wr_req_vld,
  output logic                                               wr_req_rdy,
  input  logic [ICACHE_WAY_WIDTH-1:0]                        wr_req_way,
  input  logic [ICACHE_INDEX_WIDTH-1:0]                      wr_req_index,
  input  logic                                               rsp_rdy,
  output logic                                               ram_en,
  output logic                                               ram_we,
  output logic [ICACHE_WAY_WIDTH-1:0]                        ram_way,
  output logic [ICACHE_INDEX_WIDTH-1:0]                      ram_index,
  output logic                                               rd_rsp_vld,
  output logic [MSHR_ENTRY_INDEX_WIDTH-1:0]                  rd_rsp_entry,
  output logic [ICACHE_REQ_TXNID_WIDTH-1:0]                  rd_rsp_txnid
);

  // Handshake: a request is consumed in the cycle vld & rdy are both high; requesters hold
  // vld and payload stable until then. Grants are combinational, so rdy never waits on vld history.

  dataram_sched_req_t                 rd_req [MSHR_ENTRY_NUM];
  dataram_sched_req_t                 rd_sel;
  logic [MSHR_ENTRY_INDEX_WIDTH-1:0]  rr_ptr;
  logic [MSHR_ENTRY_INDEX_WIDTH-1:0]  arb_idx;
  logic [MSHR_ENTRY_NUM-1:0]          arb_gnt;
  logic                               arb_vld;
  logic [WR_STREAK_WIDTH-1:0]         wr_streak;
  logic                               rd_elig;
  logic                               starve;
  logic                               rd_grant;
  logic                               rsp_vld_q;
  logic [MSHR_ENTRY_INDEX_WIDTH-1:0]  rsp_entry_q;
  logic [ICACHE_REQ_TXNID_WIDTH-1:0]  rsp_txnid_q;

  for (genvar g = 0; g < MSHR_ENTRY_NUM; g++) begin : g_unpack
    assign rd_req[g] = {v_rd_req_way[g*ICACHE_WAY_WIDTH +: ICACHE_WAY_WIDTH],
                        v_rd_req_index[g*ICACHE_INDEX_WIDTH +: ICACHE_INDEX_WIDTH],
                        v_rd_req_txnid[g*ICACHE_REQ_TXNID_WIDTH +: ICACHE_REQ_TXNID_WIDTH]};
  end

  icache_rr_arbiter #(
    .N     (MSHR_ENTRY_NUM),
    .IDX_W (MSHR_ENTRY_INDEX_WIDTH)
  ) u_rr_arb (
    .req     (v_rd_req_vld),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // A read only counts as eligible when the response consumer can take the beat next cycle.
  assign rd_elig      = arb_vld & rsp_rdy;
  assign starve       = rd_elig & (wr_streak == WR_STREAK_WIDTH'(MAX_WR_BURST));
  assign wr_req_rdy   = ~rst & wr_req_vld & ~starve;
  assign rd_grant     = ~rst & rd_elig & ~wr_req_rdy;
  assign v_rd_req_rdy = rd_grant ? arb_gnt : '0;
  assign rd_sel       = rd_req[arb_idx];

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_way   = '0;
    ram_index = '0;
    if (wr_req_rdy) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_way   = wr_req_way;
      ram_index = wr_req_index;
    end else if (rd_grant) begin
      ram_en    = 1'b1;
      ram_way   = rd_sel.way;
      ram_index = rd_sel.index;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      wr_streak   <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_entry_q <= '0;
      rsp_txnid_q <= '0;
    end else begin
      rsp_vld_q <= rd_grant;
      if (rd_grant) begin
        rr_ptr      <= next_rr_ptr(arb_idx);
        rsp_entry_q <= arb_idx;
        rsp_txnid_q <= rd_sel.txnid;
      end
      // Streak only measures writes that actually held off a ready read.
      if (rd_grant || !rd_elig) begin
        wr_streak <= '0;
      end else if (wr_req_rdy && (wr_streak != WR_STREAK_WIDTH'(MAX_WR_BURST))) begin
        wr_streak <= wr_streak + WR_STREAK_WIDTH'(1);
      end
    end
  end

  // A reset landing right after a grant drops the in-flight response immediately.
  assign rd_rsp_vld   = rsp_vld_q & ~rst;
  assign rd_rsp_entry = rst ? '0 : rsp_entry_q;
  assign rd_rsp_txnid = rst ? '0 : rsp_txnid_q;

endmodule

// File: tb/tb_icache_dataram_sched.sv
// Directed bench for icache_dataram_sched: per-scenario tasks check grants inline,
// a response scoreboard checks rd_rsp_* against an expected queue.
module tb_icache_dataram_sched;
  import toy_pack::*;

  logic                                             clk = 1'b0;
  logic                                             rst;
  logic [MSHR_ENTRY_NUM-1:0]                        v_rd_req_vld;
  logic [MSHR_ENTRY_NUM*ICACHE_WAY_WIDTH-1:0]       v_rd_req_way;
  logic [MSHR_ENTRY_NUM*ICACHE_INDEX_WIDTH-1:0]     v_rd_req_index;
  logic [MSHR_ENTRY_NUM*ICACHE_REQ_TXNID_WIDTH-1:0] v_rd_req_txnid;
  logic [MSHR_ENTRY_NUM-1:0]                        v_rd_req_rdy;
  logic                                             wr_req_vld;
  logic                                             wr_req_rdy;
  logic [ICACHE_WAY_WIDTH-1:0]                      wr_req_way;
  logic [ICACHE_INDEX_WIDTH-1:0]                    wr_req_index;
  logic                                             rsp_rdy;
  logic                                             ram_en;
  logic                                             ram_we;
  logic [ICACHE_WAY_WIDTH-1:0]                      ram_way;
  logic [ICACHE_INDEX_WIDTH-1:0]                    ram_index;
  logic                                             rd_rsp_vld;
  logic [MSHR_ENTRY_INDEX_WIDTH-1:0]                rd_rsp_entry;
  logic [ICACHE_REQ_TXNID_WIDTH-1:0]                rd_rsp_txnid;

  icache_dataram_sched dut (
    .clk            (clk),
    .rst            (rst),
    .v_rd_req_vld   (v_rd_req_vld),
    .v_rd_req_way   (v_rd_req_way),
    .v_rd_req_index (v_rd_req_index),
    .v_rd_req_txnid (v_rd_req_txnid),
    .v_rd_req_rdy   (v_rd_req_rdy),
    .wr_req_vld     (wr_req_vld),
    .wr_req_rdy     (wr_req_rdy),
    .wr_req_way     (wr_req_way),
    .wr_req_index   (wr_req_index),
    .rsp_rdy        (rsp_rdy),
    .ram_en         (ram_en),
    .ram_we         (ram_we),
    .ram_way        (ram_way),
    .ram_index      (ram_index),
    .rd_rsp_vld     (rd_rsp_vld),
    .rd_rsp_entry   (rd_rsp_entry),
    .rd_rsp_txnid   (rd_rsp_txnid)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [10:0] exp_q[$];
  logic [10:0] mon_exp;
  logic [18:0] obs;

  logic                              pay_way [MSHR_ENTRY_NUM];
  logic [ICACHE_INDEX_WIDTH-1:0]     pay_idx [MSHR_ENTRY_NUM];
  logic [ICACHE_REQ_TXNID_WIDTH-1:0] pay_txn [MSHR_ENTRY_NUM];

  assign obs = {v_rd_req_rdy, wr_req_rdy, ram_en, ram_we, ram_way, ram_index};

  function automatic logic [18:0] rd_exp(input int e);
    logic [7:0] oh;
    oh    = '0;
    oh[e] = 1'b1;
    return {oh, 1'b0, 1'b1, 1'b0, pay_way[e], pay_idx[e]};
  endfunction

  function automatic logic [18:0] wr_exp(input logic way, input logic [6:0] idx);
    return {8'h00, 1'b1, 1'b1, 1'b1, way, idx};
  endfunction

  // ---------------- response scoreboard ----------------
  always @(negedge clk) begin
    #1;
    if (rd_rsp_vld) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rsp_unexpected: got entry %0d txnid %h, expected no response",
                 rd_rsp_entry, rd_rsp_txnid);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({rd_rsp_entry, rd_rsp_txnid} !== mon_exp) begin
          miscompares++;
          $display("FAIL rsp_data: got entry %0d txnid %h, expected entry %0d txnid %h",
                   rd_rsp_entry, rd_rsp_txnid, mon_exp[10:8], mon_exp[7:0]);
        end
      end
    end else if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      mon_exp = exp_q.pop_front();
      $display("FAIL rsp_missing: rd_rsp_vld 0, expected entry %0d txnid %h",
               mon_exp[10:8], mon_exp[7:0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    v_rd_req_vld = '0;
    wr_req_vld   = 1'b0;
    rsp_rdy      = 1'b1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [30:0] got;
    rst          = 1'b1;
    v_rd_req_vld = '1;
    wr_req_vld   = 1'b1;
    rsp_rdy      = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #2;
      got = {obs, rd_rsp_vld, rd_rsp_entry, rd_rsp_txnid};
      vectors++;
      if (got !== 31'h0) begin
        miscompares++;
        $display("FAIL reset_outputs: got %h, expected 0", got);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #2;
    vectors++;
    if ({obs, rd_rsp_vld} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_release_idle: got %h, expected 0", {obs, rd_rsp_vld});
    end
  endtask

  task automatic test_basic_read();
    logic [18:0] exp_g;
    @(negedge clk);
    rsp_rdy      = 1'b1;
    v_rd_req_vld = 8'b0000_0100;
    #2;
    exp_g = {8'h04, 1'b0, 1'b1, 1'b0, 1'b1, 7'h15};
    vectors++;
    if (obs !== exp_g) begin
      miscompares++;
      $display("FAIL basic_read_grant: got %h, expected %h", obs, exp_g);
    end
    exp_q.push_back({3'd2, 8'h3A});
    @(negedge clk);
    v_rd_req_vld = '0;
    #2;
    vectors++;
    if (obs !== 19'h0) begin
      miscompares++;
      $display("FAIL basic_read_idle: got %h, expected 0", obs);
    end
  endtask

  task automatic test_round_robin();
    logic [18:0] exp_g;
    int e;
    pulse_reset();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      rsp_rdy      = 1'b1;
      v_rd_req_vld = '1;
      #2;
      e     = k % MSHR_ENTRY_NUM;
      exp_g = rd_exp(e);
      vectors++;
      if (obs !== exp_g) begin
        miscompares++;
        $display("FAIL rr_grant_%0d: got %h, expected %h", k, obs, exp_g);
      end
      exp_q.push_back({3'(e), pay_txn[e]});
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_starvation();
    logic [18:0] exp_g;
    @(negedge clk);
    wr_req_vld   = 1'b1;
    wr_req_way   = 1'b0;
    wr_req_index = 7'h55;
    v_rd_req_vld = 8'b0010_0000;
    rsp_rdy      = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c != 0) @(negedge clk);
      #2;
      exp_g = (c % 5 == 4) ? rd_exp(5) : wr_exp(1'b0, 7'h55);
      vectors++;
      if (obs !== exp_g) begin
        miscompares++;
        $display("FAIL starve_cycle_%0d: got %h, expected %h", c, obs, exp_g);
      end
      if (c % 5 == 4) exp_q.push_back({3'd5, pay_txn[5]});
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [18:0] exp_g;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rsp_rdy      = 1'b0;
      v_rd_req_vld = 8'b0100_0010;
      #2;
      vectors++;
      if (obs !== 19'h0) begin
        miscompares++;
        $display("FAIL bp_blocked_%0d: got %h, expected 0", c, obs);
      end
    end
    @(negedge clk);
    rsp_rdy = 1'b1;
    #2;
    exp_g = rd_exp(6);
    vectors++;
    if (obs !== exp_g) begin
      miscompares++;
      $display("FAIL bp_release_grant: got %h, expected %h", obs, exp_g);
    end
    exp_q.push_back({3'd6, pay_txn[6]});
    // Writes while reads are blocked must not build up the streak.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rsp_rdy      = 1'b0;
      v_rd_req_vld = 8'b0000_0010;
      wr_req_vld   = 1'b1;
      wr_req_way   = 1'b1;
      wr_req_index = 7'h2B;
      #2;
      exp_g = wr_exp(1'b1, 7'h2B);
      vectors++;
      if (obs !== exp_g) begin
        miscompares++;
        $display("FAIL bp_write_%0d: got %h, expected %h", c, obs, exp_g);
      end
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rsp_rdy = 1'b1;
      #2;
      exp_g = (c == 4) ? rd_exp(1) : wr_exp(1'b1, 7'h2B);
      vectors++;
      if (obs !== exp_g) begin
        miscompares++;
        $display("FAIL bp_streak_%0d: got %h, expected %h", c, obs, exp_g);
      end
      if (c == 4) exp_q.push_back({3'd1, pay_txn[1]});
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_midflight();
    logic [18:0] exp_g;
    @(negedge clk);
    v_rd_req_vld = 8'b0001_0000;
    rsp_rdy      = 1'b1;
    #2;
    exp_g = rd_exp(4);
    vectors++;
    if (obs !== exp_g) begin
      miscompares++;
      $display("FAIL mid_grant: got %h, expected %h", obs, exp_g);
    end
    exp_q.push_back({3'd4, pay_txn[4]});
    @(negedge clk);
    rst          = 1'b1;
    v_rd_req_vld = '0;
    exp_q.delete();
    for (int c = 1; c <= 2; c++) begin
      if (c == 2) @(negedge clk);
      #2;
      vectors++;
      if ({rd_rsp_vld, obs} !== 20'h0) begin
        miscompares++;
        $display("FAIL mid_rst_n_plus_%0d: got %h, expected 0", c, {rd_rsp_vld, obs});
      end
    end
    @(negedge clk);
    rst          = 1'b0;
    v_rd_req_vld = '1;
    #2;
    exp_g = rd_exp(0);
    vectors++;
    if (obs !== exp_g) begin
      miscompares++;
      $display("FAIL mid_ptr_cleared: got %h, expected %h", obs, exp_g);
    end
    exp_q.push_back({3'd0, pay_txn[0]});
    @(negedge clk);
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < MSHR_ENTRY_NUM; i++) begin
      pay_way[i] = (i == 2) ? 1'b1 : 1'(i % 2);
      pay_idx[i] = (i == 2) ? 7'h15 : 7'(8'h40 + i);
      pay_txn[i] = (i == 2) ? 8'h3A : 8'(8'hA0 + i);
      v_rd_req_way[i]                          = pay_way[i];
      v_rd_req_index[i*ICACHE_INDEX_WIDTH +: ICACHE_INDEX_WIDTH]         = pay_idx[i];
      v_rd_req_txnid[i*ICACHE_REQ_TXNID_WIDTH +: ICACHE_REQ_TXNID_WIDTH] = pay_txn[i];
    end
    rst          = 1'b1;
    wr_req_way   = 1'b0;
    wr_req_index = '0;
    idle_inputs();

    test_reset();
    test_basic_read();
    test_round_robin();
    test_starvation();
    test_backpressure();
    test_reset_midflight();

    repeat (3) @(negedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
